// File: rtl/reg_file_mp_if.sv
// Bundle of read, write and reserve signals for the multi-port register file.
// The pipeline control drives the master side; the register file is the slave.
interface reg_file_mp_if #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2
);
  logic [NUM_READ*ADDR_W-1:0] read_addr;
  logic [NUM_READ*DATA_W-1:0] read_out;
  logic [NUM_READ-1:0]        busy;
  logic                       write_en0;
  logic [ADDR_W-1:0]          write_addr0;
  logic [DATA_W-1:0]          write_data0;
  logic                       write_en1;
  logic [ADDR_W-1:0]          write_addr1;
  logic [DATA_W-1:0]          write_data1;
  logic                       reserve_en;
  logic [ADDR_W-1:0]          reserve_addr;

  modport master (
    output read_addr, write_en0, write_addr0, write_data0,
           write_en1, write_addr1, write_data1, reserve_en, reserve_addr,
    input  read_out, busy
  );

  modport slave (
    input  read_addr, write_en0, write_addr0, write_data0,
           write_en1, write_addr1, write_data1, reserve_en, reserve_addr,
    output read_out, busy
  );
endinterface

// File: rtl/reg_file_mp.sv
// Parametrised register file: two write ports (port 1 wins), N read ports,
// optional zero register, write bypass, optional registered reads, pending scoreboard.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int READ_REG = 0
) (
  input logic          clk,
  input logic          reset,
  reg_file_mp_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0]          regs_q [DEPTH];
  logic [DATA_W-1:0]          regs_d [DEPTH];
  logic [DEPTH-1:0]           pending_q, pending_d;
  logic                       wr0_ok, wr1_ok, rsv_ok;
  logic [NUM_READ*DATA_W-1:0] rd_data;
  logic [NUM_READ-1:0]        rd_busy;
  logic [ADDR_W-1:0]          ra;

  // Address 0 is masked here once so nothing downstream can touch it.
  always_comb begin
    wr0_ok = bus.write_en0  && !((ZERO_REG != 0) && (bus.write_addr0  == '0));
    wr1_ok = bus.write_en1  && !((ZERO_REG != 0) && (bus.write_addr1  == '0));
    rsv_ok = bus.reserve_en && !((ZERO_REG != 0) && (bus.reserve_addr == '0));
  end

  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    if (wr0_ok) begin
      regs_d[bus.write_addr0]    = bus.write_data0;
      pending_d[bus.write_addr0] = 1'b0;
    end
    if (wr1_ok) begin
      regs_d[bus.write_addr1]    = bus.write_data1;
      pending_d[bus.write_addr1] = 1'b0;
    end
    // A reserve announces a new producer, so it overrides a same-cycle write-back.
    if (rsv_ok) pending_d[bus.reserve_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: the storage array is reset because a cleared register file is architecturally visible.
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) regs_q[k] <= '0;
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int i = 0; i < NUM_READ; i++) begin
      ra                          = bus.read_addr[i*ADDR_W +: ADDR_W];
      rd_data[i*DATA_W +: DATA_W] = regs_q[ra];
      rd_busy[i]                  = pending_q[ra];
      if (BYPASS != 0) begin
        if (wr0_ok && (bus.write_addr0 == ra)) begin
          rd_data[i*DATA_W +: DATA_W] = bus.write_data0;
          rd_busy[i]                  = rsv_ok && (bus.reserve_addr == ra);
        end
        if (wr1_ok && (bus.write_addr1 == ra)) begin
          rd_data[i*DATA_W +: DATA_W] = bus.write_data1;
          rd_busy[i]                  = rsv_ok && (bus.reserve_addr == ra);
        end
      end
    end
  end

  if (READ_REG != 0) begin : g_rd_reg
    logic [NUM_READ*DATA_W-1:0] read_out_q, read_out_d;
    logic [NUM_READ-1:0]        busy_q, busy_d;

    always_comb begin
      read_out_d = rd_data;
      busy_d     = rd_busy;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
      if (reset) begin
        read_out_q <= '0;
        busy_q     <= '0;
      end else begin
        read_out_q <= read_out_d;
        busy_q     <= busy_d;
      end
    end

    assign bus.read_out = read_out_q;
    assign bus.busy     = busy_q;
  end else begin : g_rd_comb
    assign bus.read_out = rd_data;
    assign bus.busy     = rd_busy;
  end
endmodule

// File: tb/tb_reg_file_mp.sv
// Drives a bypassing combinational-read instance and a non-bypassing registered-read
// instance with identical stimulus and compares both against an array-based model.
module tb_reg_file_mp;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR)) if_a ();
  reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR)) if_b ();

  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .ZERO_REG(1), .BYPASS(1), .READ_REG(0))
    dut_a (.clk(clk), .reset(reset), .bus(if_a));
  reg_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR), .ZERO_REG(1), .BYPASS(0), .READ_REG(1))
    dut_b (.clk(clk), .reset(reset), .bus(if_b));

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem  [DEPTH];
  logic          pend [DEPTH];
  logic          model_valid = 1'b0;
  logic [DW-1:0] exp_b_data [NR];
  logic          exp_b_busy [NR];

  logic [AW-1:0] c_ra [NR];
  logic          c_we0, c_we1, c_re;
  logic [AW-1:0] c_a0, c_a1, c_rsa;
  logic [DW-1:0] c_d0, c_d1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic write_hit(input logic [AW-1:0] ra);
    return ra != 0 && ((c_we0 && c_a0 == ra) || (c_we1 && c_a1 == ra));
  endfunction

  function automatic logic [DW-1:0] bypass_data(input logic [AW-1:0] ra);
    logic [DW-1:0] v;
    v = mem[ra];
    if (ra != 0 && c_we0 && c_a0 == ra) v = c_d0;
    if (ra != 0 && c_we1 && c_a1 == ra) v = c_d1;
    return v;
  endfunction

  function automatic logic bypass_busy(input logic [AW-1:0] ra);
    if (write_hit(ra)) return c_re && c_rsa == ra;
    return pend[ra];
  endfunction

  task automatic drive(input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                       input logic we0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic re, input logic [AW-1:0] rsa, input logic rst);
    c_ra[0] = r0; c_ra[1] = r1;
    c_we0 = we0; c_a0 = a0; c_d0 = d0;
    c_we1 = we1; c_a1 = a1; c_d1 = d1;
    c_re = re; c_rsa = rsa;
    reset = rst;
    if_a.read_addr = {r1, r0};  if_b.read_addr = {r1, r0};
    if_a.write_en0 = we0;       if_b.write_en0 = we0;
    if_a.write_addr0 = a0;      if_b.write_addr0 = a0;
    if_a.write_data0 = d0;      if_b.write_data0 = d0;
    if_a.write_en1 = we1;       if_b.write_en1 = we1;
    if_a.write_addr1 = a1;      if_b.write_addr1 = a1;
    if_a.write_data1 = d1;      if_b.write_data1 = d1;
    if_a.reserve_en = re;       if_b.reserve_en = re;
    if_a.reserve_addr = rsa;    if_b.reserve_addr = rsa;
    #1;
    for (int i = 0; i < NR; i++) begin
      if (model_valid) begin
        check($sformatf("a_data%0d@%0d", i, c_ra[i]), if_a.read_out[i*DW +: DW], bypass_data(c_ra[i]));
        check($sformatf("a_busy%0d@%0d", i, c_ra[i]), {31'b0, if_a.busy[i]}, {31'b0, bypass_busy(c_ra[i])});
      end
      exp_b_data[i] = rst ? '0 : mem[c_ra[i]];
      exp_b_busy[i] = rst ? 1'b0 : pend[c_ra[i]];
    end
  endtask

  task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    drive(r0, r1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] = '0;
        pend[k] = 1'b0;
      end
      model_valid = 1'b1;
    end else begin
      if (c_we0 && c_a0 != 0) begin mem[c_a0] = c_d0; pend[c_a0] = 1'b0; end
      if (c_we1 && c_a1 != 0) begin mem[c_a1] = c_d1; pend[c_a1] = 1'b0; end
      if (c_re && c_rsa != 0) pend[c_rsa] = 1'b1;
    end
    #1;
    for (int i = 0; i < NR; i++) begin
      check($sformatf("b_data%0d@%0d", i, c_ra[i]), if_b.read_out[i*DW +: DW], exp_b_data[i]);
      check($sformatf("b_busy%0d@%0d", i, c_ra[i]), {31'b0, if_b.busy[i]}, {31'b0, exp_b_busy[i]});
    end
    @(negedge clk);
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  initial begin
    // Reset, then sweep every address on both read ports.
    drive(0, 0, 1, 3, 32'h1234, 0, 0, 0, 1, 4, 1);
    tick();
    for (int i = 0; i < DEPTH / 2; i++) begin
      idle(AW'(2 * i), AW'(2 * i + 1));
      check("rst_a_data0", if_a.read_out[0 +: DW], 32'd0);
      check("rst_a_busy", {30'b0, if_a.busy}, 32'd0);
      tick();
    end

    // Basic write/read.
    drive(0, 0, 1, 15, 32'd101010, 0, 0, 0, 0, 0, 0);
    tick();
    drive(15, 28, 1, 28, 32'd5400, 0, 0, 0, 0, 0, 0);
    check("basic_p0", if_a.read_out[0 +: DW], 32'd101010);
    check("basic_p1", if_a.read_out[DW +: DW], 32'd5400);
    tick();
    check("basic_b_p0", if_b.read_out[0 +: DW], 32'd101010);
    idle(15, 28);
    tick();
    check("basic_b_p1", if_b.read_out[DW +: DW], 32'd5400);

    // Dual-write conflict and distinct dual write.
    drive(20, 0, 1, 20, 32'd265, 1, 20, 32'd34567, 0, 0, 0);
    check("conflict_bypass", if_a.read_out[0 +: DW], 32'd34567);
    tick();
    idle(20, 20);
    check("conflict_stored", if_a.read_out[0 +: DW], 32'd34567);
    tick();
    drive(0, 0, 1, 1, 32'd7, 1, 2, 32'd9, 0, 0, 0);
    tick();
    idle(1, 2);
    check("dual_a1", if_a.read_out[0 +: DW], 32'd7);
    check("dual_a2", if_a.read_out[DW +: DW], 32'd9);
    tick();

    // Bypass versus pre-write capture.
    drive(5, 0, 1, 5, 32'd77, 0, 0, 0, 0, 0, 0);
    check("bypass_a", if_a.read_out[0 +: DW], 32'd77);
    tick();
    check("nobypass_b_old", if_b.read_out[0 +: DW], 32'd0);
    idle(5, 0);
    tick();
    check("nobypass_b_new", if_b.read_out[0 +: DW], 32'd77);

    // Zero register.
    drive(0, 0, 1, 0, 32'hFFFF_FFFF, 1, 0, 32'hFFFF_FFFF, 1, 0, 0);
    check("zero_same", if_a.read_out[0 +: DW], 32'd0);
    check("zero_busy_same", {31'b0, if_a.busy[0]}, 32'd0);
    tick();
    idle(0, 0);
    check("zero_after", if_a.read_out[0 +: DW], 32'd0);
    check("zero_busy_after", {31'b0, if_a.busy[0]}, 32'd0);
    tick();

    // Scoreboard.
    drive(9, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
    check("sb_not_yet", {31'b0, if_a.busy[0]}, 32'd0);
    tick();
    idle(9, 0);
    check("sb_reserved", {31'b0, if_a.busy[0]}, 32'd1);
    tick();
    check("sb_b_reserved", {31'b0, if_b.busy[0]}, 32'd1);
    drive(9, 0, 1, 9, 32'd3, 0, 0, 0, 0, 0, 0);
    check("sb_bypass_clear", {31'b0, if_a.busy[0]}, 32'd0);
    tick();
    idle(9, 0);
    check("sb_cleared", {31'b0, if_a.busy[0]}, 32'd0);
    check("sb_data3", if_a.read_out[0 +: DW], 32'd3);
    tick();
    drive(9, 0, 1, 9, 32'd44, 0, 0, 0, 1, 9, 0);
    check("sb_rsv_wr_same", {31'b0, if_a.busy[0]}, 32'd1);
    tick();
    idle(9, 0);
    check("sb_rsv_wr_busy", {31'b0, if_a.busy[0]}, 32'd1);
    check("sb_rsv_wr_data", if_a.read_out[0 +: DW], 32'd44);
    tick();
    drive(9, 0, 0, 0, 0, 0, 0, 0, 1, 9, 1);
    tick();
    check("sb_b_reset", {31'b0, if_b.busy[0]}, 32'd0);
    idle(9, 0);
    check("sb_reset_busy", {31'b0, if_a.busy[0]}, 32'd0);
    check("sb_reset_data", if_a.read_out[0 +: DW], 32'd0);
    tick();

    // Randomised traffic with address collisions favoured.
    for (int n = 0; n < 400; n++) begin
      drive(rand_addr(), rand_addr(),
            1'($urandom_range(0, 1)), rand_addr(), DW'($urandom),
            1'($urandom_range(0, 1)), rand_addr(), DW'($urandom),
            1'($urandom_range(0, 2) == 0), rand_addr(),
            1'($urandom_range(0, 49) == 0));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
